// File: rtl/fp_add_arbiter.sv
// Shares one combinational single-precision adder between two requesters; grant alternates on contention.
// Latency: accept edge E0 -> resp_valid after edge E0+SETTLE_CYCLES; one op in flight at a time.
// Backpressure: requesters see ready only in IDLE; the result is held in DONE until resp_ready.
module fp_add_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_sub,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_id,
    output logic        busy,
    output logic [15:0] op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t      state, state_nxt;
    logic [31:0] op_a, op_b, sum;
    logic [3:0]  cnt;
    logic        id, last_grant, gnt_id, accept, resp_hs;

    fp_adder u_adder (.a(op_a), .b(op_b), .y(sum));

    always_comb begin
        gnt_id     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        req0_ready = (state == IDLE) && !gnt_id && req0_valid;
        req1_ready = (state == IDLE) && gnt_id && req1_valid;
        accept     = req0_ready || req1_ready;
        resp_hs    = resp_valid && resp_ready;
        state_nxt  = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    if (resp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            resp_id    <= 1'b0;
            op_count   <= 16'd0;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            id         <= 1'b0;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                // Subtraction is folded into a sign flip of B so the adder only ever adds.
                op_a       <= gnt_id ? req1_a : req0_a;
                op_b       <= gnt_id ? {req1_b[31] ^ req1_sub, req1_b[30:0]}
                                     : {req0_b[31] ^ req0_sub, req0_b[30:0]};
                id         <= gnt_id;
                last_grant <= gnt_id;
                cnt        <= CNT_INIT;
            end
            if (state == EXEC) begin
                if (cnt == 4'd0) begin
                    resp_data  <= sum;
                    resp_id    <= id;
                    resp_valid <= 1'b1;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
            if (state == DONE && resp_hs) begin
                resp_valid <= 1'b0;
                op_count   <= op_count + 16'd1;
            end
        end
    end
endmodule

// Combinational IEEE-754 single-precision adder, round-to-nearest-even, subnormals supported.
// Latency: purely combinational.
// Backpressure: none.
module fp_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic        swap, sub, s_big, s_sml, sticky, rnd_up, a_nan, b_nan, a_inf, b_inf;
    logic [7:0]  e_big, e_sml, d;
    logic [23:0] m_big, m_sml;
    logic [26:0] x_big, x_sml, x_shr, mask, norm;
    logic [27:0] sum;
    logic [9:0]  e_res;
    logic [4:0]  lz;
    logic [24:0] mant;

    always_comb begin
        a_nan  = (&a[30:23]) && (|a[22:0]);
        b_nan  = (&b[30:23]) && (|b[22:0]);
        a_inf  = (&a[30:23]) && !(|a[22:0]);
        b_inf  = (&b[30:23]) && !(|b[22:0]);
        swap   = b[30:0] > a[30:0];
        s_big  = swap ? b[31] : a[31];
        s_sml  = swap ? a[31] : b[31];
        e_big  = swap ? b[30:23] : a[30:23];
        e_sml  = swap ? a[30:23] : b[30:23];
        m_big  = {e_big != 8'd0, swap ? b[22:0] : a[22:0]};
        m_sml  = {e_sml != 8'd0, swap ? a[22:0] : b[22:0]};
        // Subnormals sit at exponent 1 without the hidden bit.
        d      = (e_big == 8'd0 ? 8'd1 : e_big) - (e_sml == 8'd0 ? 8'd1 : e_sml);
        x_big  = {m_big, 3'b000};
        x_sml  = {m_sml, 3'b000};
        mask   = 27'd0;
        if (d > 8'd26) begin
            x_shr  = 27'd0;
            sticky = |m_sml;
        end else begin
            x_shr  = x_sml >> d;
            mask   = (27'd1 << d) - 27'd1;
            sticky = |(x_sml & mask);
        end
        x_shr[0] = x_shr[0] | sticky;
        sub    = s_big ^ s_sml;
        sum    = sub ? ({1'b0, x_big} - {1'b0, x_shr}) : ({1'b0, x_big} + {1'b0, x_shr});
        e_res  = {2'b00, (e_big == 8'd0) ? 8'd1 : e_big};
        lz     = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            e_res = e_res + 10'd1;
        end else if ({5'd0, lz} >= e_res) begin
            norm  = sum[26:0] << (e_res - 10'd1);
            e_res = 10'd1;
        end else begin
            norm  = sum[26:0] << lz;
            e_res = e_res - {5'd0, lz};
        end
        rnd_up = norm[2] && (norm[1] || norm[0] || norm[3]);
        mant   = {1'b0, norm[26:3]} + {24'd0, rnd_up};
        if (mant[24]) begin
            mant  = {1'b0, mant[24:1]};
            e_res = e_res + 10'd1;
        end
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] ^ b[31])))
            y = 32'h7FC0_0000;
        else if (a_inf || b_inf)
            y = a_inf ? a : b;
        else if (sum == 28'd0)
            y = {!sub && s_big, 31'd0};
        else if (e_res >= 10'd255)
            y = {s_big, 8'hFF, 23'd0};
        else
            y = {s_big, mant[23] ? e_res[7:0] : 8'd0, mant[22:0]};
    end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Randomised scoreboard bench: requester drivers push expected results, a monitor pops on each response.
`timescale 1ns/1ps
module tb_fp_add_arbiter;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_sub, req1_valid, req1_ready, req1_sub;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, resp_data;
    logic        resp_valid, resp_ready, resp_id, busy;
    logic [15:0] op_count;

    fp_add_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          acc_log[$];
    int          pop_ids[$];
    int          n_checks = 0, n_fail = 0, cyc = 0, model_count = 0, last_hs_cyc = 0;
    logic        model_last = 1'b1;
    logic [1:0]  rv = 2'b00;
    logic [31:0] ra[2], rb[2];
    logic        rs[2];
    logic        rr = 1'b1, rst_d = 1'b1, refill = 1'b0, prev_vld = 1'b0;
    logic [31:0] last_data;
    logic        last_id;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic real sp2real(input logic [31:0] f);
        logic [63:0] dbits;
        if (f[30:0] == 31'd0) dbits = {f[31], 63'd0};
        else dbits = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(dbits);
    endfunction

    // Round a double (exact sum of two singles) to single precision, nearest-even.
    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] dbits;
        logic [24:0] m;
        logic [28:0] rest;
        logic [10:0] e;
        logic        up;
        dbits = $realtobits(r);
        if (dbits[62:52] == 11'd0) return {dbits[63], 31'd0};
        m    = {2'b01, dbits[51:29]};
        rest = dbits[28:0];
        up   = (rest > 29'h1000_0000) || (rest == 29'h1000_0000 && m[0]);
        m    = m + 25'(up);
        e    = dbits[62:52] - 11'd896;
        if (m[24]) begin
            m = m >> 1;
            e = e + 11'd1;
        end
        return {dbits[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b, input logic s);
        return real2sp(sp2real(a) + sp2real({b[31] ^ s, b[30:0]}));
    endfunction

    // Exponents within 28 of each other keep the double-precision sum exact.
    function automatic logic [31:0] rand_fp();
        if ($urandom_range(0, 15) == 0) return {1'($urandom), 31'd0};
        return {1'($urandom), 8'($urandom_range(110, 138)), 23'($urandom)};
    endfunction

    task automatic load(input int k, input logic [31:0] a, input logic [31:0] b, input logic s);
        ra[k] = a;
        rb[k] = b;
        rs[k] = s;
        rv[k] = 1'b1;
    endtask

    task automatic load_rand(input int k);
        logic [31:0] a;
        a = rand_fp();
        load(k, a, ($urandom_range(0, 7) == 0) ? a : rand_fp(), 1'($urandom));
    endtask

    task automatic step();
        logic [1:0] exp_rdy;
        @(negedge clk);
        rst = rst_d;
        req0_valid = rv[0]; req0_a = ra[0]; req0_b = rb[0]; req0_sub = rs[0];
        req1_valid = rv[1]; req1_a = ra[1]; req1_b = rb[1]; req1_sub = rs[1];
        resp_ready = rr;
        if (rst_d) begin
            sb_q.delete();
            model_last  = 1'b1;
            model_count = 0;
        end
        #1;
        if (!rst) begin
            exp_rdy = 2'b00;
            if (sb_q.size() == 0) begin
                exp_rdy[0] = rv[0] && (!rv[1] || model_last);
                exp_rdy[1] = rv[1] && (!rv[0] || !model_last);
            end
            check("ready", 32'({req1_ready, req0_ready}), 32'(exp_rdy));
            check("busy", 32'(busy), 32'(sb_q.size() != 0));
            check("op_count", 32'(op_count), 32'(model_count & 16'hFFFF));
            for (int k = 0; k < 2; k++) begin
                if (rv[k] && (k == 0 ? req0_ready : req1_ready)) begin
                    exp_t ent;
                    ent.id   = 1'(k);
                    ent.data = golden(ra[k], rb[k], rs[k]);
                    ent.cyc  = cyc;
                    sb_q.push_back(ent);
                    acc_log.push_back(cyc);
                    model_last = 1'(k);
                    rv[k] = 1'b0;
                    if (refill) load_rand(k);
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || rv != 2'b00) && n < budget) begin
            step();
            n++;
        end
        check("drain_in_budget", 32'(sb_q.size() != 0 || rv != 2'b00), 32'd0);
    endtask

    // Monitor: compares every presented response against the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_vld = 1'b0;
        end else if (sb_q.size() == 0) begin
            check("no_spurious_resp", 32'(resp_valid), 32'd0);
            prev_vld = 1'b0;
        end else if (resp_valid) begin
            if (!prev_vld) check("latency", 32'(cyc), 32'(sb_q[0].cyc + 1 + SETTLE));
            check("resp_data", resp_data, sb_q[0].data);
            check("resp_id", 32'(resp_id), 32'(sb_q[0].id));
            prev_vld = 1'b1;
            if (resp_ready) begin
                last_data = resp_data;
                last_id   = resp_id;
                pop_ids.push_back(int'(sb_q[0].id));
                void'(sb_q.pop_front());
                model_count++;
                last_hs_cyc = cyc;
                prev_vld = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c0, t0;
        logic [31:0] hold_d;
        logic        hold_id;
        rst = 1'b1; resp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_sub = 1'b0; req1_sub = 1'b0;
        req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
        ra[0] = 32'd0; rb[0] = 32'd0; ra[1] = 32'd0; rb[1] = 32'd0; rs[0] = 1'b0; rs[1] = 1'b0;

        // Reset with req0 pending, then 2.0 + 1.0.
        load(0, 32'h4000_0000, 32'h3F80_0000, 1'b0);
        rst_d = 1'b1;
        step(); step();
        @(posedge clk); #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_d = 1'b0;
        drain(40);
        check("add_result", last_data, 32'h4040_0000);
        check("add_id", 32'(last_id), 32'd0);

        // 3.0 - 1.0 from requester 1.
        load(1, 32'h4040_0000, 32'h3F80_0000, 1'b1);
        drain(40);
        check("sub_result", last_data, 32'h4000_0000);
        check("sub_id", 32'(last_id), 32'd1);

        // Both requesters continuously valid.
        pop_ids.delete(); acc_log.delete();
        c0 = model_count;
        refill = 1'b1;
        load_rand(0); load_rand(1);
        n = 0;
        while (pop_ids.size() < 4 && n < 100) begin step(); n++; end
        check("fair_count", 32'(model_count - c0), 32'd4);
        for (int i = 0; i < 4; i++) check("fair_id", 32'(pop_ids[i]), 32'(i % 2));
        check("fair_cycles", 32'(last_hs_cyc - acc_log[0]), 32'(4 * (SETTLE + 2) - 1));
        refill = 1'b0;
        drain(60);

        // Hold the result under backpressure with requester 1 waiting.
        rr = 1'b0;
        load_rand(0);
        n = 0;
        while (!resp_valid && n < 30) begin step(); n++; end
        check("bp_resp_seen", 32'(resp_valid), 32'd1);
        hold_d = resp_data; hold_id = resp_id;
        load_rand(1);
        repeat (5) begin
            step();
            check("bp_hold_data", resp_data, hold_d);
            check("bp_hold_id", 32'(resp_id), 32'(hold_id));
        end
        c0 = model_count;
        rr = 1'b1;
        step(); step();
        check("bp_one_handshake", 32'(op_count), 32'(c0 + 1));
        drain(60);

        // Reset while the adder is settling (cnt == 2).
        acc_log.delete();
        load_rand(0);
        n = 0;
        while (acc_log.size() == 0 && n < 20) begin step(); n++; end
        step();
        rst_d = 1'b1;
        step();
        @(posedge clk); #1;
        check("exec_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("exec_rst_busy", 32'(busy), 32'd0);
        check("exec_rst_op_count", 32'(op_count), 32'd0);
        rst_d = 1'b0;
        load(1, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
        drain(40);
        check("post_rst_result", last_data, 32'h4000_0000);
        check("post_rst_count", 32'(op_count), 32'd1);

        // Random traffic with random backpressure.
        repeat (600) begin
            for (int k = 0; k < 2; k++)
                if (!rv[k] && $urandom_range(0, 2) == 0) load_rand(k);
            rr = ($urandom_range(0, 3) != 0);
            step();
        end
        rr = 1'b1;
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
